reaction_timer: RTL and testbench
=================================

# reaction_timer

Top-level reaction-time game for a 100 MHz FPGA board. After a pseudo-random wait it lights a "go" LED, measures the time until the player presses btn[0] in milliseconds, and shows the result (0000–9999) on a multiplexed 4-digit 7-segment display driven through ck_io0..ck_io11. This is the complete design; it sits directly between the board pins and the clock.

## Interface
- CLK_HZ, 100_000_000, clock frequency; the 1 ms tick is every CLK_HZ/1000 cycles.
- MIN_DELAY_MS, 1000, minimum wait before "go".
- RAND_MASK, 2047, mask applied to the LFSR; wait = MIN_DELAY_MS + (lfsr & RAND_MASK) ms.
- REFRESH_CYCLES, 100_000, cycles each digit is enabled during display scanning.
- clk  in  1  system clock; sole clock.
- ck_rst  in  1  reset; asynchronous and active-high.
- btn  in  4  push buttons; btn[0] = react, btn[1] = restart, btn[3:2] unused.
- ck_io0..ck_io6  out  1 each  segments a..g, active-high.
- ck_io7  out  1  decimal point, always 0.
- ck_io8..ck_io11  out  1 each  digit enables, active-low; ck_io8 = ones, ck_io11 = thousands.
- leds  out  4  [0] = go, [1] = waiting, [2] = result valid, [3] = false start.

## Operation
- btn bits pass through a 2-flop synchronizer. A press is the rising edge of the synchronized bit.
- A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1) is seeded to 0xACE1 on reset and advances every clk.
- State WAIT (entered on reset release or restart):
  - latch the target on entry;
  - leds = 4'b0010;
  - count ms ticks;
  - when the count reaches the target, go to GO.
- State GO:
  - leds = 4'b0001;
  - the 4-digit BCD counter starts at 0000 and increments on each ms tick;
  - it saturates at 9999;
  - a btn[0] press moves to DONE.
- State DONE:
  - leds = 4'b0100;
  - the BCD value is frozen and displayed;
  - a btn[1] press moves to WAIT.
- State FAULT (only with the macro):
  - leds = 4'b1000;
  - the display shows 0000;
  - a btn[1] press moves to WAIT.
- During WAIT and GO the display shows the live BCD counter. It reads 0000 in WAIT.
- btn[0] in DONE is ignored. btn[1] in WAIT or GO is ignored.
- The display scanner cycles through ones→tens→hundreds→thousands, REFRESH_CYCLES per digit. Exactly one enable is low at a time.

## Timing
- Reset values (asynchronous):
  - leds = 0000;
  - segments = 0;
  - all digit enables = 1;
  - state = WAIT, which takes effect on the first edge after release;
  - BCD counter = 0;
  - ms prescaler = 0;
  - scan index = ones.
- Reset mid-operation aborts any state, with the same values as above.
- The ms prescaler is free-running from reset and is not re-phased on state change. The measured value therefore has a −0/+1 ms quantization.
- Press latency:
  - 2 cycles of synchronizer, plus 1 cycle of edge detection, then the state register updates on the next edge;
  - the BCD counter stops in the same cycle the state becomes DONE.
- If a press and a ms tick coincide in GO, the tick is counted and then the counter freezes.
- The BCD carry chain is combinational within one cycle. 9→0 carries propagate to the next digit.

## Configuration
- REACTION_TIMER_FALSE_START_EN:
  - defined: a btn[0] press during WAIT enters FAULT;
  - undefined: btn[0] in WAIT is ignored and FAULT is unreachable; leds[3] stays 0.

## Structure
- Package reaction_timer_pkg:
  - state enum (WAIT, GO, DONE, FAULT);
  - 7-segment decode constants for BCD 0–9;
  - the LFSR seed and tap constant.
- One sub-module, seg7_mux:
  - takes 4×4-bit BCD;
  - owns the scan counter, digit-enable rotation and BCD-to-segment decode;
  - drives ck_io0..ck_io11.

## Test plan
- Reset held 10 µs: all digit enables = 1, leds = 0000. After release, leds = 0010 within 2 cycles.
- After release, wait for leds = 0001. Assert btn[0] 200 ms later → leds = 0100, displayed digits 0,2,0,0 (value 200 or 201).
- Never press in GO for 10 s → display saturates at 9999 and stays there; leds remain 0001.
- In DONE, press btn[1] → leds = 0010, display 0000. The new wait is ≥ MIN_DELAY_MS.
- With the macro, btn[0] during WAIT → leds = 1000, display 0000. Without the macro → leds stay 0010.
- Assert reset while in GO → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-time game: FSM states, LED
// patterns, LFSR seed/taps and the 7-segment glyph table.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_GO    = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [3:0] LEDS_GO    = 4'b0001;
  localparam logic [3:0] LEDS_WAIT  = 4'b0010;
  localparam logic [3:0] LEDS_DONE  = 4'b0100;
  localparam logic [3:0] LEDS_FAULT = 4'b1000;

  // x^16 + x^14 + x^13 + x^11 + 1 expressed as a mask over bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Segment patterns {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg7_of(input logic [3:0] d);
    seg7_of = 7'h00;
    if (d <= 4'd9) seg7_of = SEG_DIGITS[d];
  endfunction

endpackage

// File: rtl/seg7_mux.sv
// Multiplexed 4-digit 7-segment driver: rotates one active-low digit enable
// every REFRESH_CYCLES clocks and decodes the selected BCD digit.
module seg7_mux
  import reaction_timer_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  output logic [11:0] io
);

  localparam int RC_W = $clog2(REFRESH_CYCLES + 1);

  logic [RC_W-1:0] dwell;
  logic [1:0]      idx;
  logic [3:0]      digit;

  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0: digit = bcd[3:0];
      2'd1: digit = bcd[7:4];
      2'd2: digit = bcd[11:8];
      2'd3: digit = bcd[15:12];
    endcase
  end

  // Enables and segments are registered together so they always change on
  // the same edge and never show a ghost of the neighbouring digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= '0;
      idx   <= 2'd0;
      io    <= {4'hF, 1'b0, 7'h00};
    end else begin
      if (dwell == RC_W'(REFRESH_CYCLES - 1)) begin
        dwell <= '0;
        idx   <= idx + 2'd1;
      end else begin
        dwell <= dwell + 1'b1;
      end
      io <= {~(4'b0001 << idx), 1'b0, seg7_of(digit)};
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game top: random wait, "go" LED, millisecond BCD timer and
// 7-segment display. Optional false-start detection: REACTION_TIMER_FALSE_START_EN.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int MIN_DELAY_MS   = 1000,
  parameter int RAND_MASK      = 2047,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       ck_rst,
  input  logic [3:0] btn,
  output logic       ck_io0,
  output logic       ck_io1,
  output logic       ck_io2,
  output logic       ck_io3,
  output logic       ck_io4,
  output logic       ck_io5,
  output logic       ck_io6,
  output logic       ck_io7,
  output logic       ck_io8,
  output logic       ck_io9,
  output logic       ck_io10,
  output logic       ck_io11,
  output logic [3:0] leds
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PRE_W    = $clog2(TICK_DIV + 1);

  logic [1:0]       sync_p0, sync_p1, sync_prev;
  logic [1:0]       press;
  logic             unused_btn;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [15:0]      lfsr;
  state_t           state;
  logic             armed;
  logic [15:0]      target;
  logic [15:0]      wait_ms;
  logic [15:0]      bcd;
  logic [11:0]      io;

  assign unused_btn = ^btn[3:2];

  function automatic logic [15:0] bcd_sat_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Button synchronizer and rising-edge detect
  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      sync_p0   <= 2'b00;
      sync_p1   <= 2'b00;
      sync_prev <= 2'b00;
    end else begin
      sync_p0   <= btn[1:0];
      sync_p1   <= sync_p0;
      sync_prev <= sync_p1;
    end
  end

  assign press = sync_p1 & ~sync_prev;
  assign tick  = (pre == PRE_W'(TICK_DIV - 1));

  // Free-running ms prescaler and LFSR; neither is re-phased by the FSM.
  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      pre  <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  // armed=0 marks the first WAIT cycle, where the random target is latched.
  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      state   <= ST_WAIT;
      leds    <= 4'b0000;
      armed   <= 1'b0;
      target  <= 16'd0;
      wait_ms <= 16'd0;
      bcd     <= 16'd0;
    end else begin
      case (state)
        ST_WAIT: begin
          leds <= LEDS_WAIT;
          if (!armed) begin
            target  <= 16'(MIN_DELAY_MS) + (lfsr & 16'(RAND_MASK));
            wait_ms <= 16'd0;
            armed   <= 1'b1;
          end
`ifdef REACTION_TIMER_FALSE_START_EN
          else if (press[0]) begin
            state <= ST_FAULT;
            leds  <= LEDS_FAULT;
            bcd   <= 16'd0;
          end
`endif
          else if (wait_ms == target) begin
            state <= ST_GO;
            leds  <= LEDS_GO;
            bcd   <= 16'd0;
          end else if (tick) begin
            wait_ms <= wait_ms + 16'd1;
          end
        end
        ST_GO: begin
          if (tick) bcd <= bcd_sat_inc(bcd);
          if (press[0]) begin
            state <= ST_DONE;
            leds  <= LEDS_DONE;
          end
        end
        ST_DONE, ST_FAULT: begin
          if (press[1]) begin
            state <= ST_WAIT;
            leds  <= LEDS_WAIT;
            armed <= 1'b0;
            bcd   <= 16'd0;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  seg7_mux #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_seg7_mux (
    .clk (clk),
    .rst (ck_rst),
    .bcd (bcd),
    .io  (io)
  );

  assign ck_io0  = io[0];
  assign ck_io1  = io[1];
  assign ck_io2  = io[2];
  assign ck_io3  = io[3];
  assign ck_io4  = io[4];
  assign ck_io5  = io[5];
  assign ck_io6  = io[6];
  assign ck_io7  = io[7];
  assign ck_io8  = io[8];
  assign ck_io9  = io[9];
  assign ck_io10 = io[10];
  assign ck_io11 = io[11];

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer with a scaled clock (4 cycles per ms) so the full
// 9999 ms saturation fits in a short run.
`timescale 1ns/1ps
module tb_reaction_timer;

  localparam int CLK_HZ  = 4000;
  localparam int MIN_MS  = 100;
  localparam int RMASK   = 15;
  localparam int REFRESH = 4;
  localparam int DIV     = CLK_HZ / 1000;
`ifdef REACTION_TIMER_FALSE_START_EN
  localparam int FS_LEDS = 8;
`else
  localparam int FS_LEDS = 2;
`endif

  logic clk = 1'b0;
  logic ck_rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic ck_io0, ck_io1, ck_io2, ck_io3, ck_io4, ck_io5, ck_io6, ck_io7;
  logic ck_io8, ck_io9, ck_io10, ck_io11;
  logic [3:0] leds;
  wire [6:0] seg = {ck_io6, ck_io5, ck_io4, ck_io3, ck_io2, ck_io1, ck_io0};
  wire [3:0] en  = {ck_io11, ck_io10, ck_io9, ck_io8};

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reaction_timer #(
    .CLK_HZ(CLK_HZ), .MIN_DELAY_MS(MIN_MS), .RAND_MASK(RMASK), .REFRESH_CYCLES(REFRESH)
  ) dut (
    .clk(clk), .ck_rst(ck_rst), .btn(btn),
    .ck_io0(ck_io0), .ck_io1(ck_io1), .ck_io2(ck_io2), .ck_io3(ck_io3),
    .ck_io4(ck_io4), .ck_io5(ck_io5), .ck_io6(ck_io6), .ck_io7(ck_io7),
    .ck_io8(ck_io8), .ck_io9(ck_io9), .ck_io10(ck_io10), .ck_io11(ck_io11),
    .leds(leds)
  );

  typedef struct {
    logic [3:0] b;
    int         hold;
    int         leds_exp;
    int         disp_exp;
  } step_t;

  step_t steps [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dec7(input logic [6:0] s);
    case (s)
      7'h3F: return 0;
      7'h06: return 1;
      7'h5B: return 2;
      7'h4F: return 3;
      7'h66: return 4;
      7'h6D: return 5;
      7'h7D: return 6;
      7'h07: return 7;
      7'h7F: return 8;
      7'h6F: return 9;
      default: return -1;
    endcase
  endfunction

  // Scans a full refresh rotation; returns -1 on any malformed frame.
  task automatic read_display(output int val);
    int dig [4];
    bit okay;
    int pos;
    int d;
    okay = 1'b1;
    for (int i = 0; i < 4; i++) dig[i] = -1;
    repeat (4 * REFRESH + 4) begin
      @(negedge clk);
      case (en)
        4'b1110: pos = 0;
        4'b1101: pos = 1;
        4'b1011: pos = 2;
        4'b0111: pos = 3;
        default: begin pos = -1; okay = 1'b0; end
      endcase
      if (ck_io7) okay = 1'b0;
      if (pos >= 0) begin
        d = dec7(seg);
        if (d < 0) okay = 1'b0;
        else if (dig[pos] >= 0 && dig[pos] != d) okay = 1'b0;
        dig[pos] = d;
      end
    end
    for (int i = 0; i < 4; i++) if (dig[i] < 0) okay = 1'b0;
    val = okay ? dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0] : -1;
  endtask

  task automatic wait_go(input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (leds == 4'b0001) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse(input logic [3:0] b, input int hold);
    btn = b;
    repeat (hold) @(negedge clk);
    btn = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int v;
    int ok;
    longint t0;
    longint t1;
    int cyc;

    steps[0] = '{4'b0000, 2, 1, 9999};
    steps[1] = '{4'b0001, 6, 4, 9999};
    steps[2] = '{4'b0001, 6, 4, 9999};
    steps[3] = '{4'b0010, 6, 2, 0};
    steps[4] = '{4'b0010, 6, 2, 0};
    steps[5] = '{4'b0001, 6, FS_LEDS, 0};
    steps[6] = '{4'b0010, 6, 2, 0};

    repeat (1000) @(negedge clk);
    chk("rst_leds", int'(leds), 0);
    chk("rst_enables", int'(en), 15);
    chk("rst_segments", int'({ck_io7, seg}), 0);

    ck_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("wait_leds_after_release", int'(leds), 2);
    read_display(v);
    chk("wait_display", v, 0);

    wait_go(2000, ok);
    chk("go_reached", ok, 1);
    repeat (200 * DIV) @(negedge clk);
    pulse(4'b0001, 6);
    chk("done_leds", int'(leds), 4);
    read_display(v);
    total++;
    if (v != 200 && v != 201) begin
      bad++;
      $display("FAIL reaction_200ms: got %0d expected 200 or 201", v);
    end

    t0 = $time;
    pulse(4'b0010, 6);
    chk("restart_leds", int'(leds), 2);
    read_display(v);
    chk("restart_display", v, 0);
    wait_go(2000, ok);
    chk("go_after_restart", ok, 1);
    t1 = $time;
    cyc = int'((t1 - t0) / 10);
    total++;
    if (cyc < MIN_MS * DIV || cyc > (MIN_MS + RMASK + 2) * DIV) begin
      bad++;
      $display("FAIL restart_wait: got %0d cycles expected %0d..%0d",
               cyc, MIN_MS * DIV, (MIN_MS + RMASK + 2) * DIV);
    end

    repeat (40100) @(negedge clk);
    chk("saturate_leds", int'(leds), 1);
    read_display(v);
    chk("saturate_display", v, 9999);

    for (int i = 0; i < 7; i++) begin
      pulse(steps[i].b, steps[i].hold);
      chk($sformatf("step%0d_leds", i), int'(leds), steps[i].leds_exp);
      read_display(v);
      chk($sformatf("step%0d_display", i), v, steps[i].disp_exp);
    end

    wait_go(2000, ok);
    chk("go_before_reset", ok, 1);
    repeat (20) @(negedge clk);
    ck_rst = 1'b1;
    #1;
    chk("async_rst_leds", int'(leds), 0);
    chk("async_rst_enables", int'(en), 15);
    chk("async_rst_segments", int'({ck_io7, seg}), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
